// File: rtl/ps2_kbd_pkg.sv
// Scan-code constants, key indices and sequencer state encoding shared by the
// PS/2 key sequencer and its event FIFO.
package ps2_kbd_pkg;

    localparam int NUM_KEYS = 9;
    localparam int EVT_W    = 5;

    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_BRK    = 8'hF0;
    localparam logic [7:0] SC_ACK    = 8'hFA;
    localparam logic [7:0] SC_BAT    = 8'hAA;
    localparam logic [7:0] SC_ECHO   = 8'hEE;
    localparam logic [7:0] SC_RESEND = 8'hFE;
    localparam logic [7:0] SC_ERR0   = 8'h00;
    localparam logic [7:0] SC_ERR1   = 8'hFF;

    localparam logic [7:0] SC_A      = 8'h1C;
    localparam logic [7:0] SC_S      = 8'h1B;
    localparam logic [7:0] SC_D      = 8'h23;
    localparam logic [7:0] SC_F      = 8'h2B;
    localparam logic [7:0] SC_SPACE  = 8'h29;
    localparam logic [7:0] SC_UP     = 8'h75;
    localparam logic [7:0] SC_DOWN   = 8'h72;
    localparam logic [7:0] SC_LEFT   = 8'h6B;
    localparam logic [7:0] SC_RIGHT  = 8'h74;

    localparam logic [3:0] KEY_A     = 4'd0;
    localparam logic [3:0] KEY_S     = 4'd1;
    localparam logic [3:0] KEY_D     = 4'd2;
    localparam logic [3:0] KEY_F     = 4'd3;
    localparam logic [3:0] KEY_SPACE = 4'd4;
    localparam logic [3:0] KEY_UP    = 4'd5;
    localparam logic [3:0] KEY_DOWN  = 4'd6;
    localparam logic [3:0] KEY_LEFT  = 4'd7;
    localparam logic [3:0] KEY_RIGHT = 4'd8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BRK     = 2'd1,
        ST_EXT     = 2'd2,
        ST_EXT_BRK = 2'd3
    } seq_state_t;

    typedef struct packed {
        logic       hit;
        logic [3:0] idx;
    } key_lookup_t;

    function automatic logic is_ignored(input logic [7:0] code);
        case (code)
            SC_ACK, SC_BAT, SC_ECHO, SC_RESEND, SC_ERR0, SC_ERR1: return 1'b1;
            default:                                              return 1'b0;
        endcase
    endfunction

    function automatic key_lookup_t lookup_key(input logic ext, input logic [7:0] code);
        key_lookup_t r;
        r.hit = 1'b1;
        r.idx = KEY_A;
        if (!ext) begin
            case (code)
                SC_A:     r.idx = KEY_A;
                SC_S:     r.idx = KEY_S;
                SC_D:     r.idx = KEY_D;
                SC_F:     r.idx = KEY_F;
                SC_SPACE: r.idx = KEY_SPACE;
                default:  r.hit = 1'b0;
            endcase
        end else begin
            case (code)
                SC_UP:    r.idx = KEY_UP;
                SC_DOWN:  r.idx = KEY_DOWN;
                SC_LEFT:  r.idx = KEY_LEFT;
                SC_RIGHT: r.idx = KEY_RIGHT;
                default:  r.hit = 1'b0;
            endcase
        end
        return r;
    endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// Synchronous FIFO of {key, make} events; no bypass, so a push is visible the
// cycle after it is written. The parent decides whether a push on full drops.
module ps2_evt_fifo
    import ps2_kbd_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = EVT_W
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign dout  = mem[rd_ptr];
    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/ps2_key_sequencer.sv
// PS/2 scan-code prefix sequencer: tracks pressed state of nine game keys and
// queues press/release events for the game logic.
//
//   state      | meaning
//   ST_IDLE    | no prefix pending; next byte is a make or a prefix
//   ST_BRK     | F0 seen; next byte is a non-extended break
//   ST_EXT     | E0 seen; next byte is an extended make or F0
//   ST_EXT_BRK | E0 F0 seen; next byte is an extended break
module ps2_key_sequencer
    import ps2_kbd_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                CLOCK_50,
    input  logic                reset,
    input  logic [7:0]          received_data,
    input  logic                received_data_en,
    output logic [NUM_KEYS-1:0] key_state,
    output logic                evt_valid,
    input  logic                evt_ready,
    output logic [3:0]          evt_key,
    output logic                evt_make,
    output logic                overflow
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    seq_state_t          state;
    seq_state_t          state_nxt;
    logic [CNT_W-1:0]    tmo_cnt;
    logic                tmo_hit;
    logic                do_make;
    logic                do_break;
    logic                code_ext;
    key_lookup_t         lk;
    logic                key_pressed;
    logic                push_req;
    logic                fifo_push;
    logic                fifo_pop;
    logic                fifo_full;
    logic                fifo_empty;
    logic [EVT_W-1:0]    fifo_dout;
    logic [NUM_KEYS-1:0] key_state_nxt;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            tmo_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (received_data_en || state_nxt == ST_IDLE) begin
                tmo_cnt <= '0;
            end else begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
        end
    end

    assign tmo_hit = (state != ST_IDLE) && (tmo_cnt == CNT_LAST);

    // A strobe always wins over a timeout landing in the same cycle.
    always_comb begin
        state_nxt = state;
        do_make   = 1'b0;
        do_break  = 1'b0;
        code_ext  = 1'b0;
        if (received_data_en) begin
            case (state)
                ST_IDLE: begin
                    if (received_data == SC_EXT) begin
                        state_nxt = ST_EXT;
                    end else if (received_data == SC_BRK) begin
                        state_nxt = ST_BRK;
                    end else if (!is_ignored(received_data)) begin
                        do_make = 1'b1;
                    end
                end
                ST_BRK: begin
                    do_break  = 1'b1;
                    state_nxt = ST_IDLE;
                end
                ST_EXT: begin
                    code_ext = 1'b1;
                    if (received_data == SC_BRK) begin
                        state_nxt = ST_EXT_BRK;
                    end else if (received_data != SC_EXT) begin
                        do_make   = 1'b1;
                        state_nxt = ST_IDLE;
                    end
                end
                ST_EXT_BRK: begin
                    code_ext  = 1'b1;
                    do_break  = 1'b1;
                    state_nxt = ST_IDLE;
                end
                default: state_nxt = ST_IDLE;
            endcase
        end else if (tmo_hit) begin
            state_nxt = ST_IDLE;
        end
    end

    assign lk          = lookup_key(code_ext, received_data);
    assign key_pressed = key_state[lk.idx];
    assign push_req    = lk.hit && ((do_make && !key_pressed) || (do_break && key_pressed));
    assign fifo_pop    = evt_valid && evt_ready;
    assign fifo_push   = push_req && (!fifo_full || fifo_pop);

    always_comb begin
        key_state_nxt = key_state;
        if (lk.hit && do_make) begin
            key_state_nxt[lk.idx] = 1'b1;
        end else if (lk.hit && do_break) begin
            key_state_nxt[lk.idx] = 1'b0;
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            key_state <= '0;
            overflow  <= 1'b0;
        end else begin
            key_state <= key_state_nxt;
            if (push_req && fifo_full && !fifo_pop) begin
                overflow <= 1'b1;
            end
        end
    end

    ps2_evt_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (EVT_W)
    ) u_evt_fifo (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .push     (fifo_push),
        .pop      (fifo_pop),
        .din      ({lk.idx, do_make}),
        .dout     (fifo_dout),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign evt_valid = !fifo_empty;
    assign evt_key   = fifo_dout[4:1];
    assign evt_make  = fifo_dout[0];

endmodule

// File: tb/tb_ps2_key_sequencer.sv
// Scoreboard bench for ps2_key_sequencer: expected events are queued as bytes
// are sent and matched against each handshake on the event port.
module tb_ps2_key_sequencer;

    localparam int DEPTH = 4;
    localparam int TMO   = 16;

    logic       CLOCK_50 = 1'b0;
    logic       reset    = 1'b1;
    logic [7:0] received_data = 8'h00;
    logic       received_data_en = 1'b0;
    logic [8:0] key_state;
    logic       evt_valid;
    logic       evt_ready = 1'b1;
    logic [3:0] evt_key;
    logic       evt_make;
    logic       overflow;

    int n_cmp = 0;
    int n_err = 0;
    logic [4:0] exp_q[$];
    logic [4:0] mon_exp;

    always #10 CLOCK_50 = ~CLOCK_50;

    ps2_key_sequencer #(
        .FIFO_DEPTH     (DEPTH),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .CLOCK_50         (CLOCK_50),
        .reset            (reset),
        .received_data    (received_data),
        .received_data_en (received_data_en),
        .key_state        (key_state),
        .evt_valid        (evt_valid),
        .evt_ready        (evt_ready),
        .evt_key          (evt_key),
        .evt_make         (evt_make),
        .overflow         (overflow)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Every accepted event must match the oldest expectation.
    always @(negedge CLOCK_50) begin
        if (!reset && evt_valid && evt_ready) begin
            if (exp_q.size() == 0) begin
                chk("evt_unexpected_qsize", exp_q.size(), 1);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("evt", {evt_key, evt_make}, mon_exp);
            end
        end
    end

    task automatic expect_evt(input logic [3:0] key, input logic mk);
        exp_q.push_back({key, mk});
    endtask

    task automatic send(input logic [7:0] b);
        @(posedge CLOCK_50); #1;
        received_data    = b;
        received_data_en = 1'b1;
        @(posedge CLOCK_50); #1;
        received_data_en = 1'b0;
    endtask

    task automatic send_b2b(input logic [7:0] a, input logic [7:0] b);
        @(posedge CLOCK_50); #1;
        received_data    = a;
        received_data_en = 1'b1;
        @(posedge CLOCK_50); #1;
        received_data    = b;
        @(posedge CLOCK_50); #1;
        received_data_en = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge CLOCK_50);
        #1;
    endtask

    task automatic drain(input string tag);
        int i = 0;
        while ((exp_q.size() != 0 || evt_valid) && i < 200) begin
            @(posedge CLOCK_50);
            i++;
        end
        #1;
        chk({tag, "_qsize"}, exp_q.size(), 0);
        chk({tag, "_valid"}, evt_valid, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        idle(3);
        chk("rst_key_state", key_state, 0);
        chk("rst_valid", evt_valid, 0);
        chk("rst_key", evt_key, 0);
        chk("rst_make", evt_make, 0);
        chk("rst_overflow", overflow, 0);
        @(posedge CLOCK_50); #1;
        reset = 1'b0;
        idle(2);

        // A press and release
        expect_evt(4'd0, 1'b1);
        send(8'h1C);
        chk("a_press_ks", key_state, 9'h001);
        expect_evt(4'd0, 1'b0);
        send(8'hF0);
        send(8'h1C);
        chk("a_release_ks", key_state, 9'h000);
        drain("a");

        // Extended Up, prefix and code on consecutive cycles
        expect_evt(4'd5, 1'b1);
        send_b2b(8'hE0, 8'h75);
        chk("up_press_ks", key_state, 9'h020);
        expect_evt(4'd5, 1'b0);
        send(8'hE0);
        send(8'hF0);
        send(8'h75);
        chk("up_release_ks", key_state, 9'h000);
        drain("up");

        // Typematic Space, release, then release of an unpressed key
        expect_evt(4'd4, 1'b1);
        send(8'h29);
        send(8'h29);
        send(8'h29);
        chk("space_ks", key_state, 9'h010);
        expect_evt(4'd4, 1'b0);
        send(8'hF0);
        send(8'h29);
        send(8'hF0);
        send(8'h2B);
        send(8'hFA);
        chk("space_rel_ks", key_state, 9'h000);
        drain("typematic");

        // Prefix still live just before the timeout: break of unpressed S
        send(8'hF0);
        idle(TMO - 4);
        send(8'h1B);
        chk("pre_tmo_ks", key_state, 9'h000);
        // Prefix expired: the same byte is a make
        send(8'hF0);
        idle(TMO + 3);
        expect_evt(4'd1, 1'b1);
        send(8'h1B);
        chk("post_tmo_ks", key_state, 9'h002);
        expect_evt(4'd1, 1'b0);
        send(8'hF0);
        send(8'h1B);
        send(8'hE0);
        idle(TMO + 3);
        send(8'h75);
        chk("ext_tmo_ks", key_state, 9'h000);
        drain("timeout");

        // Overflow with consumer stalled
        evt_ready = 1'b0;
        expect_evt(4'd0, 1'b1);
        expect_evt(4'd1, 1'b1);
        expect_evt(4'd2, 1'b1);
        expect_evt(4'd3, 1'b1);
        send(8'h1C);
        send(8'h1B);
        send(8'h23);
        send(8'h2B);
        send(8'h29);
        chk("ovf_ks", key_state, 9'h01F);
        chk("ovf_flag", overflow, 1);
        chk("ovf_valid", evt_valid, 1);
        chk("ovf_head", {evt_key, evt_make}, 5'b0000_1);
        idle(3);
        chk("ovf_head_hold", {evt_key, evt_make}, 5'b0000_1);
        evt_ready = 1'b1;
        drain("ovf");
        chk("ovf_sticky", overflow, 1);

        // Reset between E0 and F0
        send(8'hE0);
        reset = 1'b1;
        idle(2);
        chk("mid_rst_ks", key_state, 0);
        chk("mid_rst_valid", evt_valid, 0);
        chk("mid_rst_key", evt_key, 0);
        chk("mid_rst_make", evt_make, 0);
        chk("mid_rst_ovf", overflow, 0);
        reset = 1'b0;
        idle(1);
        expect_evt(4'd0, 1'b1);
        send(8'h1C);
        chk("post_rst_ks", key_state, 9'h001);
        drain("post_rst");

        // Fill the FIFO, then push and pop in the same cycle
        evt_ready = 1'b0;
        expect_evt(4'd1, 1'b1);
        expect_evt(4'd2, 1'b1);
        expect_evt(4'd3, 1'b1);
        expect_evt(4'd4, 1'b1);
        send(8'h1B);
        send(8'h23);
        send(8'h2B);
        send(8'h29);
        send(8'hE0);
        expect_evt(4'd5, 1'b1);
        @(posedge CLOCK_50); #1;
        received_data    = 8'h75;
        received_data_en = 1'b1;
        evt_ready        = 1'b1;
        @(posedge CLOCK_50); #1;
        received_data_en = 1'b0;
        evt_ready        = 1'b0;
        chk("full_pp_ovf", overflow, 0);
        chk("full_pp_head", {evt_key, evt_make}, 5'b0010_1);
        evt_ready = 1'b1;
        drain("full_pp");
        chk("full_pp_ks", key_state, 9'h03F);
        chk("full_pp_ovf_end", overflow, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
